// File: rtl/varredura_pkg.sv
// Shared definitions for the display scan controller: slot phase, anode
// constants and the digit-to-anode decode used by the output register.
package varredura_pkg;

    typedef enum logic {
        APAGA = 1'b0,
        EXIBE = 1'b1
    } fase_t;

    localparam int         NUM_DIGITOS     = 4;
    localparam logic [3:0] ANODOS_APAGADOS = 4'b1111;

    // One-hot-low anode pattern lighting the given digit.
    function automatic logic [3:0] anodoDe(input logic [1:0] dig);
        logic [3:0] umQuente;
        umQuente = 4'b0001 << dig;
        return ~umQuente;
    endfunction

endpackage

// File: rtl/divisor_varredura.sv
// Slot prescaler: counts enabled cycles 0..DIVISOR-1 and flags the last
// cycle of the slot and, with VARREDURA_APAGAMENTO_EN, the last blank cycle.
// A low enable clears the count so a resumed slot always starts fresh.
module divisor_varredura #(
    parameter int DIVISOR    = 50000,
    parameter int APAGAMENTO = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic habilita,
`ifdef VARREDURA_APAGAMENTO_EN
    output logic fim_apagamento,
`endif
    output logic tick
);
    import varredura_pkg::*;

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CW-1:0] cont;

    // Prescaler: wraps at the end of the slot, cleared by reset or disable.
    always_ff @(posedge clock) begin
        if (reset || !habilita)
            cont <= '0;
        else if (cont == CW'(DIVISOR - 1))
            cont <= '0;
        else
            cont <= cont + 1'b1;
    end

    assign tick = habilita && (cont == CW'(DIVISOR - 1));

`ifdef VARREDURA_APAGAMENTO_EN
    assign fim_apagamento = habilita && (cont == CW'(APAGAMENTO - 1));
`endif

endmodule

// File: rtl/controle_varredura.sv
// Four-digit display scan controller. Drives the 4:1 source mux selects and
// the matching active-low anodes, all straight from flops. Optional dead time
// at the start of every slot is enabled by defining VARREDURA_APAGAMENTO_EN.
module controle_varredura #(
    parameter int DIVISOR    = 50000,
    parameter int APAGAMENTO = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    output logic       chave0,
    output logic       chave1,
    output logic [3:0] anodo,
    output logic       fim_quadro
);
    import varredura_pkg::*;

    if (DIVISOR < 2) begin : g_divErr
        $error("controle_varredura: DIVISOR must be at least 2");
    end
`ifdef VARREDURA_APAGAMENTO_EN
    if (APAGAMENTO < 1 || APAGAMENTO >= DIVISOR) begin : g_apagErr
        $error("controle_varredura: APAGAMENTO must be in 1..DIVISOR-1");
    end
`endif

    logic [1:0] digito;
    // Set once a slot is running; the first enabled edge after reset or a
    // disable only opens the slot, so the prescaler sees DIVISOR full cycles.
    logic       ativo;
    logic       tick;
    logic       contaHab;

    assign contaHab = habilita && ativo;

`ifdef VARREDURA_APAGAMENTO_EN
    fase_t fase;
    logic  fimApag;

    divisor_varredura #(.DIVISOR(DIVISOR), .APAGAMENTO(APAGAMENTO)) uDiv (
        .clock          (clock),
        .reset          (reset),
        .habilita       (contaHab),
        .fim_apagamento (fimApag),
        .tick           (tick)
    );
`else
    divisor_varredura #(.DIVISOR(DIVISOR), .APAGAMENTO(APAGAMENTO)) uDiv (
        .clock    (clock),
        .reset    (reset),
        .habilita (contaHab),
        .tick     (tick)
    );
`endif

    // Digit advance, phase and registered anode / frame outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            digito     <= 2'd0;
            ativo      <= 1'b0;
            anodo      <= ANODOS_APAGADOS;
            fim_quadro <= 1'b0;
`ifdef VARREDURA_APAGAMENTO_EN
            fase       <= APAGA;
`endif
        end else if (!habilita) begin
            ativo      <= 1'b0;
            anodo      <= ANODOS_APAGADOS;
            fim_quadro <= 1'b0;
`ifdef VARREDURA_APAGAMENTO_EN
            fase       <= APAGA;
`endif
        end else if (!ativo) begin
            ativo      <= 1'b1;
            fim_quadro <= 1'b0;
`ifdef VARREDURA_APAGAMENTO_EN
            fase       <= APAGA;
            anodo      <= ANODOS_APAGADOS;
`else
            anodo      <= anodoDe(digito);
`endif
        end else if (tick) begin
            digito     <= digito + 2'd1;
            fim_quadro <= (digito == 2'd3);
`ifdef VARREDURA_APAGAMENTO_EN
            fase       <= APAGA;
            anodo      <= ANODOS_APAGADOS;
`else
            anodo      <= anodoDe(digito + 2'd1);
`endif
        end else begin
            fim_quadro <= 1'b0;
`ifdef VARREDURA_APAGAMENTO_EN
            if (fase == APAGA && fimApag) begin
                fase  <= EXIBE;
                anodo <= anodoDe(digito);
            end
`endif
        end
    end

    assign chave0 = digito[0];
    assign chave1 = digito[1];

endmodule

// File: tb/tb_controle_varredura.sv
// Self-checking bench for controle_varredura (DIVISOR=4, APAGAMENTO=1).
// A slot-position model pushes expected outputs at each edge; they are popped
// and compared half a cycle later. Scenario tasks add fixed-value checks.
module tb_controle_varredura;

    localparam int DIV  = 4;
    localparam int APAG = 1;
`ifdef VARREDURA_APAGAMENTO_EN
    localparam bit MAC = 1'b1;
`else
    localparam bit MAC = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] chave;
        logic [3:0] anodo;
        logic       fim;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       habilita = 1'b0;
    logic       chave0, chave1, fim_quadro;
    logic [3:0] anodo;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t sbq[$];

    // reference model state: running flag, 1-based position in slot, digit
    bit         mRun = 1'b0;
    int         mPos = 0;
    logic [1:0] mDig = 2'd0;

    controle_varredura #(.DIVISOR(DIV), .APAGAMENTO(APAG)) dut (
        .clock      (clock),
        .reset      (reset),
        .habilita   (habilita),
        .chave0     (chave0),
        .chave1     (chave1),
        .anodo      (anodo),
        .fim_quadro (fim_quadro)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] lit(input logic [1:0] d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic modelo(input logic r, input logic e);
        exp_t x;
        x.fim = 1'b0;
        if (r) begin
            mRun = 1'b0; mPos = 0; mDig = 2'd0;
        end else if (!e) begin
            mRun = 1'b0; mPos = 0;
        end else if (!mRun) begin
            mRun = 1'b1; mPos = 1;
        end else if (mPos == DIV) begin
            x.fim = (mDig == 2'd3);
            mDig  = mDig + 2'd1;
            mPos  = 1;
        end else begin
            mPos++;
        end
        x.chave = mDig;
        if (!mRun || (MAC && mPos <= APAG)) x.anodo = 4'b1111;
        else                                x.anodo = lit(mDig);
        sbq.push_back(x);
    endtask

    task automatic step(input logic r, input logic e);
        exp_t ex, ob;
        reset = r; habilita = e;
        @(posedge clock);
        modelo(r, e);
        @(negedge clock);
        cyc++;
        ex = sbq.pop_front();
        ob = '{chave: {chave1, chave0}, anodo: anodo, fim: fim_quadro};
        checks++;
        if (ob !== ex) begin
            errors++;
            $display("FAIL scoreboard cyc=%0d got chave=%b anodo=%b fim=%b expected chave=%b anodo=%b fim=%b",
                     cyc, ob.chave, ob.anodo, ob.fim, ex.chave, ex.anodo, ex.fim);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0);
        checks++;
        if ({chave1, chave0, anodo, fim_quadro} !== 7'b00_1111_0) begin
            errors++;
            $display("FAIL reset_state got %b%b %b %b expected 00 1111 0", chave1, chave0, anodo, fim_quadro);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);   // mid-slot at digit 2
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if ({chave1, chave0, anodo, fim_quadro} !== 7'b00_1111_0) begin
                errors++;
                $display("FAIL reset_midslot got %b%b %b %b expected 00 1111 0", chave1, chave0, anodo, fim_quadro);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if (anodo !== (MAC ? 4'b1111 : 4'b1110)) begin
            errors++;
            $display("FAIL reset_first_slot got anodo=%b expected %b", anodo, MAC ? 4'b1111 : 4'b1110);
        end
    endtask

    task automatic test_full_scan();
        logic [3:0] expA;
        logic [1:0] slot;
        step(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1);
            slot = 2'(i / DIV);
            expA = (MAC && (i % DIV) < APAG) ? 4'b1111 : lit(slot);
            checks++;
            if (anodo !== expA || {chave1, chave0} !== slot || fim_quadro !== 1'b0) begin
                errors++;
                $display("FAIL full_scan i=%0d got anodo=%b chave=%b fim=%b expected anodo=%b chave=%b fim=0",
                         i, anodo, {chave1, chave0}, fim_quadro, expA, slot);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if (fim_quadro !== 1'b1 || {chave1, chave0} !== 2'b00) begin
            errors++;
            $display("FAIL frame_pulse got fim=%b chave=%b expected fim=1 chave=00", fim_quadro, {chave1, chave0});
        end
        step(1'b0, 1'b1);
        checks++;
        if (fim_quadro !== 1'b0) begin
            errors++;
            $display("FAIL frame_pulse_width got fim=%b expected 0", fim_quadro);
        end
    endtask

    task automatic test_enable_drop();
        logic [3:0] expA;
        step(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1);   // first cycle of digit 2
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (anodo !== 4'b1111 || {chave1, chave0} !== 2'b10 || fim_quadro !== 1'b0) begin
                errors++;
                $display("FAIL enable_drop i=%0d got anodo=%b chave=%b fim=%b expected 1111 10 0",
                         i, anodo, {chave1, chave0}, fim_quadro);
            end
        end
        for (int i = 0; i < DIV; i++) begin
            step(1'b0, 1'b1);
            expA = (MAC && i < APAG) ? 4'b1111 : 4'b1011;
            checks++;
            if (anodo !== expA || {chave1, chave0} !== 2'b10) begin
                errors++;
                $display("FAIL resume_slot i=%0d got anodo=%b chave=%b expected %b 10",
                         i, anodo, {chave1, chave0}, expA);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if (anodo !== (MAC ? 4'b1111 : 4'b0111) || {chave1, chave0} !== 2'b11) begin
            errors++;
            $display("FAIL resume_next got anodo=%b chave=%b expected %b 11",
                     anodo, {chave1, chave0}, MAC ? 4'b1111 : 4'b0111);
        end
    endtask

    task automatic test_reset_on_wrap();
        step(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if ({chave1, chave0, anodo, fim_quadro} !== 7'b00_1111_0) begin
            errors++;
            $display("FAIL reset_on_wrap got %b%b %b %b expected 00 1111 0", chave1, chave0, anodo, fim_quadro);
        end
        step(1'b0, 1'b1);
        checks++;
        if (fim_quadro !== 1'b0) begin
            errors++;
            $display("FAIL reset_on_wrap_after got fim=%b expected 0", fim_quadro);
        end
    endtask

    task automatic test_mux();
        logic [3:0] ent [4];
        logic [3:0] outX;
        ent[0] = 4'd1; ent[1] = 4'd2; ent[2] = 4'd4; ent[3] = 4'd8;
        step(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1);
            if (anodo !== 4'b1111) begin
                outX = ent[{chave1, chave0}];
                checks++;
                if (outX !== ~anodo) begin
                    errors++;
                    $display("FAIL mux_integration i=%0d got outX=%b expected ~anodo=%b", i, outX, ~anodo);
                end
            end
        end
    endtask

    task automatic test_random();
        step(1'b1, 1'b0);
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0));
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_full_scan();
        test_enable_drop();
        test_reset_on_wrap();
        test_mux();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
